// File: rtl/hart_sched_arbiter_pkg.sv
// Shared types for the hart scheduling arbiter.
// State encodings and cluster-wide limits.
package hart_sched_arbiter_pkg;

  localparam int MAX_HARTS = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

endpackage

// File: rtl/hart_rr_pick.sv
// Rotate-priority encoder: first set mask bit strictly
// after start, wrapping, with start itself checked last.
module hart_rr_pick #(
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic [N-1:0]     mask_i,
  input  logic [SEL_W-1:0] start_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  always_comb begin
    int j;
    found_o = 1'b0;
    idx_o   = start_i;
    j       = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(start_i) + i) % N;
      if (!found_o && mask_i[j]) begin
        found_o = 1'b1;
        idx_o   = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/hart_sched_arbiter.sv
// Time-sliced hart selector with IRQ preemption.
// r_hart_sel drives every cluster mux.
module hart_sched_arbiter
  import hart_sched_arbiter_pkg::*;
#(
  parameter int N_HARTS   = 2,
  parameter int QUANTUM_W = 8,
  parameter int SEL_W     = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic [N_HARTS-1:0]   w_hart_req,
  input  logic [N_HARTS-1:0]   w_switch_ok,
  input  logic [N_HARTS-1:0]   w_irq_pend,
  input  logic                 w_hold,
  input  logic [QUANTUM_W-1:0] w_quantum,
  input  logic                 w_irq_prio_en,
  output logic [SEL_W-1:0]     r_hart_sel,
  output logic [N_HARTS-1:0]   w_hart_sel_oh,
  output logic                 r_active,
  output logic                 r_switch,
  output logic [QUANTUM_W-1:0] r_slice_cnt
);

  state_e               state_q;
  logic [SEL_W-1:0]     sel_q;
  logic                 active_q;
  logic                 switch_q;
  logic [QUANTUM_W-1:0] cnt_q;

  logic [SEL_W-1:0]     start;
  logic [N_HARTS-1:0]   irq_mask;
  logic                 req_found;
  logic [SEL_W-1:0]     req_idx;
  logic                 irq_found;
  logic [SEL_W-1:0]     irq_idx;
  logic                 boundary;
  logic [QUANTUM_W:0]   cnt_inc;
  logic                 expire;
  logic                 preempt;

  // In IDLE, starting after the last hart yields the lowest requester.
  always_comb begin
    start    = (state_q == ST_IDLE) ? SEL_W'(N_HARTS - 1) : sel_q;
    irq_mask = w_hart_req & w_irq_pend;
    boundary = w_switch_ok[sel_q] & ~w_hold;
    cnt_inc  = {1'b0, cnt_q} + 1'b1;
    expire   = cnt_inc >= {1'b0, w_quantum};
    preempt  = w_irq_prio_en & irq_found & ~w_irq_pend[sel_q];
  end

  hart_rr_pick #(
    .N     (N_HARTS),
    .SEL_W (SEL_W)
  ) u_req_pick (
    .mask_i  (w_hart_req),
    .start_i (start),
    .found_o (req_found),
    .idx_o   (req_idx)
  );

  hart_rr_pick #(
    .N     (N_HARTS),
    .SEL_W (SEL_W)
  ) u_irq_pick (
    .mask_i  (irq_mask),
    .start_i (start),
    .found_o (irq_found),
    .idx_o   (irq_idx)
  );

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      active_q <= 1'b0;
      switch_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      switch_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|w_hart_req && !w_hold) begin
            sel_q    <= req_idx;
            active_q <= 1'b1;
            switch_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (boundary) begin
            if (!w_hart_req[sel_q]) begin
              cnt_q <= '0;
              if (req_found) begin
                sel_q    <= req_idx;
                switch_q <= 1'b1;
                state_q  <= ST_SWITCH;
              end else begin
                active_q <= 1'b0;
                state_q  <= ST_IDLE;
              end
            end else if (preempt) begin
              sel_q    <= irq_idx;
              switch_q <= 1'b1;
              cnt_q    <= '0;
              state_q  <= ST_SWITCH;
            end else if (expire) begin
              cnt_q <= '0;
              if (req_idx != sel_q) begin
                sel_q    <= req_idx;
                switch_q <= 1'b1;
                state_q  <= ST_SWITCH;
              end
            end else if (cnt_q != '1) begin
              cnt_q <= cnt_inc[QUANTUM_W-1:0];
            end
          end
        end
        ST_SWITCH: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign r_hart_sel    = sel_q;
  assign r_active      = active_q;
  assign r_switch      = switch_q;
  assign r_slice_cnt   = cnt_q;
  assign w_hart_sel_oh = active_q ? (N_HARTS'(1) << sel_q) : '0;

endmodule

// File: tb/tb_hart_sched_arbiter.sv
// Directed bench for hart_sched_arbiter (4 harts).
// Hand-computed expectations, checked 1ns after each edge.
module tb_hart_sched_arbiter;

  localparam int N  = 4;
  localparam int QW = 8;
  localparam int SW = 2;

  logic          CLK = 1'b0;
  logic          RST_X;
  logic [N-1:0]  w_hart_req;
  logic [N-1:0]  w_switch_ok;
  logic [N-1:0]  w_irq_pend;
  logic          w_hold;
  logic [QW-1:0] w_quantum;
  logic          w_irq_prio_en;
  logic [SW-1:0] r_hart_sel;
  logic [N-1:0]  w_hart_sel_oh;
  logic          r_active;
  logic          r_switch;
  logic [QW-1:0] r_slice_cnt;

  int tests = 0;
  int fails = 0;

  hart_sched_arbiter #(
    .N_HARTS   (N),
    .QUANTUM_W (QW)
  ) dut (
    .CLK           (CLK),
    .RST_X         (RST_X),
    .w_hart_req    (w_hart_req),
    .w_switch_ok   (w_switch_ok),
    .w_irq_pend    (w_irq_pend),
    .w_hold        (w_hold),
    .w_quantum     (w_quantum),
    .w_irq_prio_en (w_irq_prio_en),
    .r_hart_sel    (r_hart_sel),
    .w_hart_sel_oh (w_hart_sel_oh),
    .r_active      (r_active),
    .r_switch      (r_switch),
    .r_slice_cnt   (r_slice_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST_X         = 1'b0;
    w_hart_req    = '0;
    w_switch_ok   = '0;
    w_irq_pend    = '0;
    w_hold        = 1'b0;
    w_quantum     = '0;
    w_irq_prio_en = 1'b0;
    tick();
    tick();
    chk("rst_sel", 32'(r_hart_sel), 0);
    chk("rst_active", 32'(r_active), 0);
    chk("rst_switch", 32'(r_switch), 0);
    chk("rst_cnt", 32'(r_slice_cnt), 0);
    chk("rst_oh", 32'(w_hart_sel_oh), 0);

    // two harts, quantum 0, boundary every 3 cycles
    RST_X      = 1'b1;
    w_hart_req = 4'b0011;
    tick();
    chk("idle_sel", 32'(r_hart_sel), 0);
    chk("idle_act", 32'(r_active), 1);
    chk("idle_sw", 32'(r_switch), 1);
    chk("idle_oh", 32'(w_hart_sel_oh), 32'b0001);
    tick();
    chk("run_sw0", 32'(r_switch), 0);
    w_switch_ok = 4'b1111;
    tick();
    w_switch_ok = 4'b0000;
    chk("tog1_sel", 32'(r_hart_sel), 1);
    chk("tog1_sw", 32'(r_switch), 1);
    chk("tog1_oh", 32'(w_hart_sel_oh), 32'b0010);
    tick();
    chk("tog1_sw0", 32'(r_switch), 0);
    chk("tog1_hold", 32'(r_hart_sel), 1);
    tick();
    w_switch_ok = 4'b1111;
    tick();
    w_switch_ok = 4'b0000;
    chk("tog2_sel", 32'(r_hart_sel), 0);
    chk("tog2_sw", 32'(r_switch), 1);

    // quantum 3, all requesting, boundary every cycle
    w_hart_req  = 4'b1111;
    w_quantum   = 8'd3;
    w_switch_ok = 4'b1111;
    tick();
    chk("q_cnt0", 32'(r_slice_cnt), 0);
    tick();
    chk("q_cnt1", 32'(r_slice_cnt), 1);
    tick();
    chk("q_cnt2", 32'(r_slice_cnt), 2);
    tick();
    chk("q_sel1", 32'(r_hart_sel), 1);
    chk("q_sw1", 32'(r_switch), 1);
    for (int h = 1; h < 5; h++) begin
      tick();
      chk("ql_cnt0", 32'(r_slice_cnt), 0);
      chk("ql_sel", 32'(r_hart_sel), 32'(h % 4));
      tick();
      chk("ql_cnt1", 32'(r_slice_cnt), 1);
      tick();
      chk("ql_cnt2", 32'(r_slice_cnt), 2);
      tick();
      chk("ql_next", 32'(r_hart_sel), 32'((h + 1) % 4));
      chk("ql_sw", 32'(r_switch), 1);
    end

    // skip idle hart 2; sel is 1 in SWITCH here
    w_hart_req = 4'b1011;
    w_quantum  = 8'd0;
    tick();
    tick();
    chk("skip_3", 32'(r_hart_sel), 3);
    tick();
    tick();
    chk("skip_0", 32'(r_hart_sel), 0);
    tick();
    tick();
    chk("skip_1", 32'(r_hart_sel), 1);
    tick();
    tick();
    chk("skip_3b", 32'(r_hart_sel), 3);
    w_hart_req = 4'b1001;
    tick();
    tick();
    chk("drop_0", 32'(r_hart_sel), 0);
    tick();
    tick();
    chk("drop_3", 32'(r_hart_sel), 3);
    tick();
    tick();
    chk("drop_0b", 32'(r_hart_sel), 0);

    // IRQ preemption from sel 0 at slice_cnt 2
    w_hart_req  = 4'b1111;
    w_quantum   = 8'd8;
    w_switch_ok = 4'b0000;
    tick();
    w_switch_ok = 4'b0001;
    tick();
    tick();
    chk("irq_cnt2", 32'(r_slice_cnt), 2);
    w_irq_pend    = 4'b0100;
    w_irq_prio_en = 1'b1;
    tick();
    chk("irq_sel", 32'(r_hart_sel), 2);
    chk("irq_sw", 32'(r_switch), 1);
    w_irq_pend    = '0;
    w_irq_prio_en = 1'b0;

    // same stimulus with preemption disabled
    RST_X = 1'b0;
    tick();
    RST_X       = 1'b1;
    w_switch_ok = 4'b0001;
    tick();
    chk("noirq_sel0", 32'(r_hart_sel), 0);
    tick();
    tick();
    chk("noirq_cnt2", 32'(r_slice_cnt), 2);
    w_irq_pend = 4'b0100;
    tick();
    chk("noirq_sel", 32'(r_hart_sel), 0);
    chk("noirq_cnt3", 32'(r_slice_cnt), 3);
    chk("noirq_sw", 32'(r_switch), 0);
    w_irq_pend = '0;

    // global hold freezes RUN
    w_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_sel", 32'(r_hart_sel), 0);
      chk("hold_cnt", 32'(r_slice_cnt), 3);
      chk("hold_sw", 32'(r_switch), 0);
    end
    w_hold    = 1'b0;
    w_quantum = 8'd4;
    tick();
    chk("rel_sel", 32'(r_hart_sel), 1);
    chk("rel_sw", 32'(r_switch), 1);
    chk("rel_cnt", 32'(r_slice_cnt), 0);

    // all requests drop -> IDLE
    tick();
    w_hart_req  = 4'b0000;
    w_switch_ok = 4'b1111;
    tick();
    chk("idle_act0", 32'(r_active), 0);
    chk("idle_oh0", 32'(w_hart_sel_oh), 0);
    chk("idle_sw0", 32'(r_switch), 0);
    tick();
    chk("idle_stay", 32'(r_active), 0);

    // IDLE entry held, then lowest requester picked
    w_hart_req = 4'b0100;
    w_hold     = 1'b1;
    tick();
    chk("ihold_act", 32'(r_active), 0);
    w_hold = 1'b0;
    tick();
    chk("ient_sel", 32'(r_hart_sel), 2);
    chk("ient_act", 32'(r_active), 1);
    chk("ient_sw", 32'(r_switch), 1);
    chk("ient_oh", 32'(w_hart_sel_oh), 32'b0100);
    w_hart_req = 4'b0110;
    w_quantum  = 8'd0;
    tick();
    chk("wrap_sel", 32'(r_hart_sel), 1);
    chk("wrap_sw", 32'(r_switch), 1);

    // reset during SWITCH
    RST_X = 1'b0;
    tick();
    chk("mrst_sel", 32'(r_hart_sel), 0);
    chk("mrst_act", 32'(r_active), 0);
    chk("mrst_sw", 32'(r_switch), 0);
    chk("mrst_cnt", 32'(r_slice_cnt), 0);
    chk("mrst_oh", 32'(w_hart_sel_oh), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hart_sched_arbiter.md
Name: hart_sched_arbiter

Overview:
- Parametrised successor to the fixed per-instruction round-robin hart selector in the RV cluster.
- Owns the register that selects which hart drives the shared interconnect and MMU.
- Adds a programmable time-slice quantum, interrupt-priority preemption, skipping of idle/halted harts, and a one-cycle switch handshake.
- Sits between the per-hart cores and the cluster mux logic; r_hart_sel from this block drives all cluster muxes.

Parameters:
N_HARTS, 2, number of harts arbitrated (1..16)
QUANTUM_W, 8, width of quantum counter/config
SEL_W, (N_HARTS>1 ? $clog2(N_HARTS) : 1), width of hart index

Ports:
CLK  in  1  clock
RST_X  in  1  reset; synchronous, active-low
w_hart_req  in  N_HARTS  hart runnable (not halted/WFI)
w_switch_ok  in  N_HARTS  hart at safe boundary (idle next_state, tkn, interrupt_ok, no exception/flush)
w_irq_pend  in  N_HARTS  hart has an enabled pending interrupt
w_hold  in  1  global freeze (MC mode, pagefault in flight, TLB/CSR flush)
w_quantum  in  QUANTUM_W  slice length in boundaries; 0 = switch at every boundary
w_irq_prio_en  in  1  enable interrupt preemption
r_hart_sel  out  SEL_W  selected hart index
w_hart_sel_oh  out  N_HARTS  one-hot of r_hart_sel, gated by r_active
r_active  out  1  a runnable hart is selected
r_switch  out  1  one-cycle pulse on the cycle r_hart_sel changes
r_slice_cnt  out  QUANTUM_W  boundaries consumed in current slice

Behaviour:
- Reset (RST_X=0 at posedge): r_hart_sel=0, r_active=0, r_switch=0, r_slice_cnt=0, state=IDLE. Reset mid-slice discards all state.
- States: IDLE, RUN, SWITCH.
- IDLE: if |w_hart_req, load r_hart_sel with the lowest-index requester; then r_active=1, r_switch=1 for one cycle, go to RUN. Otherwise stay in IDLE.
- RUN: a boundary event is b = w_switch_ok[sel] & !w_hold.
- On b:
  - If !w_hart_req[sel] and no other requester: go to IDLE, r_active=0.
  - Else if !w_hart_req[sel], pick next → SWITCH.
  - Else if w_irq_prio_en and some other requester has w_irq_pend while the current hart does not, pick next IRQ hart → SWITCH.
  - Else if r_slice_cnt+1 >= w_quantum (unsigned compare; always true for quantum=0), pick next → SWITCH; if the next pick equals sel, stay, clear r_slice_cnt, no pulse.
  - Else r_slice_cnt++ (saturating at all-ones).
- Pick next:
  - IRQ pick: first index after sel, in wrap-around order, that has req&irq_pend.
  - Otherwise: first index after sel, wrap-around, that has req.
  - The current hart is considered last.
- SWITCH (one cycle): r_hart_sel updated, r_switch=1, r_slice_cnt=0; next state RUN.
- Latency: boundary to new r_hart_sel is exactly 1 cycle. The switch_ok from the new hart is ignored in the SWITCH cycle.
- w_hold high freezes RUN (no count, no switch); IDLE→RUN entry is also held.
- w_quantum changing mid-slice takes effect at the next compare.
- N_HARTS=1: r_hart_sel is constant 0; r_switch pulses only on IDLE→RUN.
- w_hart_sel_oh = active ? (1<<sel) : 0. Non-selected harts see busy=1 (handled in the cluster).

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_SWITCH=2'd2
  - MAX_HARTS=16
- Sub-module hart_rr_pick: combinational rotate-priority encoder. Inputs are a mask and a start index; outputs are found and idx. Instantiated twice, for the req pick and the req&irq pick.

Test Plan:
- N=2, quantum=0, both req, switch_ok pulsed every 3 cycles → sel toggles 0,1,0 with a r_switch pulse 1 cycle after each pulse.
- N=4, quantum=3, all req, switch_ok=all-ones → each hart holds for 3 boundaries (slice_cnt 0,1,2), order 0→1→2→3→0.
- N=4, req=4'b1011, quantum=0 → sequence 0,1,3,0 (hart 2 skipped); then drop req[1] → sequence 0,3.
- N=4, quantum=8, sel=0 at slice_cnt=2, irq_pend[2]=1, irq_prio_en=1, boundary → sel=2 next cycle; same stimulus with irq_prio_en=0 → stays 0, slice_cnt=3.
- w_hold=1 for 10 cycles with switch_ok high → sel and slice_cnt unchanged, r_switch=0; release → switch on the next boundary.
- All req drop during RUN, boundary → IDLE, r_active=0, oh=0. Assert RST_X=0 mid-SWITCH → all outputs 0 on the next cycle.
